// File: rtl/alignment_collector_pkg.sv
// Shared sizing defaults, symbol encoding and width helpers
// for the multi-channel alignment collector.
package alignment_collector_pkg;

  localparam int ALN_NUM_CH   = 4;
  localparam int ALN_BP_WIDTH = 2;
  localparam int ALN_PACK     = 16;
  localparam int ALN_DEPTH    = 4;

  localparam logic [1:0] SYM_MATCH    = 2'd0;
  localparam logic [1:0] SYM_INS      = 2'd1;
  localparam logic [1:0] SYM_DEL      = 2'd2;
  localparam logic [1:0] SYM_MISMATCH = 2'd3;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/alignment_collector_pack_fifo.sv
// Per-channel symbol packer feeding a small word FIFO
// with engine hold and sticky overflow flag.
module aln_pack_fifo
  import alignment_collector_pkg::*;
#(
  parameter int BP_WIDTH = ALN_BP_WIDTH,
  parameter int PACK     = ALN_PACK,
  parameter int DEPTH    = ALN_DEPTH,
  parameter int CNT_W    = cnt_w(ALN_PACK),
  parameter int WW       = 1 + CNT_W + PACK * BP_WIDTH
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [BP_WIDTH-1:0] bp_i,
  input  logic                valid_i,
  input  logic                done_i,
  input  logic                err_clr_i,
  input  logic                pop_i,
  output logic                avail_o,
  output logic [WW-1:0]       word_o,
  output logic                hold_o,
  output logic                err_o
);

  localparam int DW = PACK * BP_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] PC_LAST  = CNT_W'(PACK - 1);
  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);

  logic [DW-1:0]    data_q, data_d, ins;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic             lastp_q, lastp_d;
  logic             err_q, err_d;
  logic             hold_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic [PW-1:0]    wp_q, rp_q;
  logic [WW-1:0]    mem [DEPTH];
  logic             push, pop, bypass;
  logic [WW-1:0]    push_word;

  always_comb begin
    data_d    = data_q;
    pc_d      = pc_q;
    lastp_d   = lastp_q;
    push      = 1'b0;
    push_word = '0;
    ins       = data_q;
    ins[int'(pc_q)*BP_WIDTH +: BP_WIDTH] = bp_i;
    if (!hold_q && valid_i) begin
      if (pc_q == PC_LAST || done_i) begin
        push      = 1'b1;
        push_word = {(pc_q == PC_LAST) ? done_i : 1'b1,
                     pc_q + CNT_W'(1), ins};
        data_d    = '0;
        pc_d      = '0;
      end else begin
        data_d = ins;
        pc_d   = pc_q + CNT_W'(1);
      end
    end else if (!hold_q && done_i) begin
      // a bare done right after a closing word is redundant
      if (pc_q != '0 || !lastp_q) begin
        push      = 1'b1;
        push_word = {1'b1, pc_q, data_q};
        data_d    = '0;
        pc_d      = '0;
      end
    end
    if (push) lastp_d = push_word[WW-1];
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (hold_q && (valid_i || done_i)) err_d = 1'b1;
  end

  // an empty FIFO passes the incoming word straight to the arbiter
  assign avail_o = (occ_q != '0) || push;
  assign word_o  = (occ_q != '0) ? mem[rp_q] : push_word;
  assign pop     = pop_i && avail_o;
  assign bypass  = pop && (occ_q == '0);
  assign occ_d   = occ_q + OW'(push) - OW'(pop);
  assign hold_o  = hold_q;
  assign err_o   = err_q;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      data_q  <= '0;
      pc_q    <= '0;
      lastp_q <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      occ_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      data_q  <= data_d;
      pc_q    <= pc_d;
      lastp_q <= lastp_d;
      err_q   <= err_d;
      occ_q   <= occ_d;
      hold_q  <= (occ_d == OCC_FULL);
      if (push && !bypass) wp_q <= wp_q + PW'(1);
      if (pop && !bypass) rp_q <= rp_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wp_q] <= push_word;
  end

endmodule

// File: rtl/alignment_collector.sv
// Multi-channel alignment result collector: per-channel packers,
// round-robin arbitration onto a single valid/ready output.
module alignment_collector
  import alignment_collector_pkg::*;
#(
  parameter int NUM_CH   = ALN_NUM_CH,
  parameter int BP_WIDTH = ALN_BP_WIDTH,
  parameter int PACK     = ALN_PACK,
  parameter int DEPTH    = ALN_DEPTH,
  parameter int CH_W     = ch_w(ALN_NUM_CH),
  parameter int CNT_W    = cnt_w(ALN_PACK)
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic [NUM_CH*BP_WIDTH-1:0] aln_bp_i,
  input  logic [NUM_CH-1:0]          aln_valid_i,
  input  logic [NUM_CH-1:0]          aln_done_i,
  output logic [NUM_CH-1:0]          hold_o,
  output logic [NUM_CH-1:0]          err_o,
  input  logic                       err_clr_i,
  output logic [PACK*BP_WIDTH-1:0]   out_data_o,
  output logic [CNT_W-1:0]           out_cnt_o,
  output logic [CH_W-1:0]            out_ch_o,
  output logic                       out_last_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int DW = PACK * BP_WIDTH;
  localparam int WW = 1 + CNT_W + DW;

  logic [NUM_CH-1:0] avail, pop;
  logic [WW-1:0]     word [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aln_pack_fifo #(
      .BP_WIDTH (BP_WIDTH),
      .PACK     (PACK),
      .DEPTH    (DEPTH),
      .CNT_W    (CNT_W),
      .WW       (WW)
    ) u_pf (
      .clk       (clk),
      .reset_i   (reset_i),
      .bp_i      (aln_bp_i[c*BP_WIDTH +: BP_WIDTH]),
      .valid_i   (aln_valid_i[c]),
      .done_i    (aln_done_i[c]),
      .err_clr_i (err_clr_i),
      .pop_i     (pop[c]),
      .avail_o   (avail[c]),
      .word_o    (word[c]),
      .hold_o    (hold_o[c]),
      .err_o     (err_o[c])
    );
  end

  logic            out_valid_q, out_last_q;
  logic [DW-1:0]   out_data_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CH_W-1:0] out_ch_q, rr_q, rr_d, sel;
  logic            take, load, found;

  assign take = out_valid_q && out_ready_i;
  assign load = !out_valid_q || out_ready_i;

  always_comb begin
    int base;
    int idx;
    base  = take ? (int'(out_ch_q) + 1) % NUM_CH : int'(rr_q);
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    pop   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (base + k) % NUM_CH;
      if (!found && avail[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    if (load && found) pop[sel] = 1'b1;
    rr_d = CH_W'(base);
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (load) begin
        out_valid_q <= found;
        if (found) begin
          {out_last_q, out_cnt_q, out_data_q} <= word[sel];
          out_ch_q <= sel;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_cnt_o   = out_cnt_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_alignment_collector.sv
// Directed bench for alignment_collector: packing, done handling,
// fairness, back-pressure, overflow and asynchronous reset.
module tb_alignment_collector;
  import alignment_collector_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [7:0]  aln_bp_i;
  logic [3:0]  aln_valid_i, aln_done_i;
  logic [3:0]  hold_o, err_o;
  logic        err_clr_i;
  logic [31:0] out_data_o;
  logic [4:0]  out_cnt_o;
  logic [1:0]  out_ch_o;
  logic        out_last_o, out_valid_o, out_ready_i;

  always #5 clk = ~clk;

  alignment_collector #(
    .NUM_CH(4), .BP_WIDTH(2), .PACK(16), .DEPTH(4),
    .CH_W(2), .CNT_W(5)
  ) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .aln_bp_i    (aln_bp_i),
    .aln_valid_i (aln_valid_i),
    .aln_done_i  (aln_done_i),
    .hold_o      (hold_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i),
    .out_data_o  (out_data_o),
    .out_cnt_o   (out_cnt_o),
    .out_ch_o    (out_ch_o),
    .out_last_o  (out_last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  typedef struct {
    int          ch;
    int          last;
    int          cnt;
    logic [31:0] data;
    int          cyc;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      rec_t r;
      r.ch   = int'(out_ch_o);
      r.last = int'(out_last_o);
      r.cnt  = int'(out_cnt_o);
      r.data = out_data_o;
      r.cyc  = cyc;
      q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input int c, input logic v, input logic d,
                     input logic [1:0] s);
    aln_valid_i[c]     = v;
    aln_done_i[c]      = d;
    aln_bp_i[c*2 +: 2] = s;
  endtask

  task automatic idle();
    aln_valid_i = '0;
    aln_done_i  = '0;
  endtask

  task automatic expect_word(input string tag, input int ch,
                             input int last, input int cnt,
                             input logic [31:0] data);
    rec_t r;
    int   w;
    w = 0;
    while (q.size() == 0 && w < 60) begin
      tick();
      w++;
    end
    if (q.size() == 0) begin
      chk({tag, "_timeout"}, q.size(), 1);
    end else begin
      r = q.pop_front();
      last_cyc = r.cyc;
      chk({tag, "_ch"}, r.ch, ch);
      chk({tag, "_last"}, r.last, last);
      chk({tag, "_cnt"}, r.cnt, cnt);
      chk({tag, "_data"}, r.data, data);
    end
  endtask

  task automatic expect_none(input string tag, input int n);
    repeat (n) tick();
    chk(tag, q.size(), 0);
  endtask

  logic [31:0] pat [4];
  logic [31:0] bpw [6];
  int          sent;
  int          prev;

  initial begin
    pat = '{32'h0000_0000, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
    bpw = '{32'hE4E4_E4E4, 32'h3939_3939, 32'h4E4E_4E4E,
            32'h9393_9393, 32'hE4E4_E4E4, 32'h3939_3939};
    out_ready_i = 1'b1;
    err_clr_i   = 1'b0;
    aln_bp_i    = '0;
    idle();
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_hold", hold_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_cnt", out_cnt_o, 0);
    reset_i = 1'b1;
    tick();

    // full word, closed by done on the 16th symbol
    for (int i = 0; i < 16; i++) begin
      sym(0, 1'b1, i == 15, 2'(i % 4));
      tick();
    end
    idle();
    chk("t1_valid_n1", out_valid_o, 1);
    tick();
    chk("t1_valid_n2", out_valid_o, 0);
    expect_word("t1", 0, 1, 16, 32'hE4E4_E4E4);

    // partial word, redundant done, end marker
    for (int i = 0; i < 5; i++) begin
      sym(2, 1'b1, 1'b0, SYM_MISMATCH);
      tick();
    end
    idle();
    sym(2, 1'b0, 1'b1, 2'd0);
    tick();
    idle();
    expect_word("t2_part", 2, 1, 5, 32'h0000_03FF);
    sym(2, 1'b0, 1'b1, 2'd0);
    tick();
    idle();
    expect_none("t2_nopush", 6);
    for (int i = 0; i < 16; i++) begin
      sym(2, 1'b1, 1'b0, SYM_INS);
      tick();
    end
    idle();
    expect_word("t2_full", 2, 0, 16, 32'h5555_5555);
    sym(2, 1'b0, 1'b1, 2'd0);
    tick();
    idle();
    expect_word("t2_mark", 2, 1, 0, 32'h0);

    // marker on ch3 moves the pointer back to 0
    sym(3, 1'b0, 1'b1, 2'd0);
    tick();
    idle();
    expect_word("t3_pre", 3, 1, 0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 4; c++) sym(c, 1'b1, 1'b0, 2'(c));
      tick();
    end
    idle();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      expect_word($sformatf("t3a_%0d", k), k, 0, 16, pat[k]);
      if (k > 0) chk($sformatf("t3a_b2b_%0d", k), last_cyc - prev, 1);
      prev = last_cyc;
    end

    for (int i = 0; i < 16; i++) begin
      sym(1, 1'b1, 1'b0, SYM_INS);
      tick();
    end
    idle();
    expect_word("t3_ch1", 1, 0, 16, 32'h5555_5555);
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 4; c++) sym(c, 1'b1, 1'b0, 2'(c));
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      expect_word($sformatf("t3b_%0d", k), (k + 2) % 4, 0, 16,
                  pat[(k + 2) % 4]);
    end

    // back-pressure on ch1
    out_ready_i = 1'b0;
    sent = 0;
    for (int t = 0; t < 100; t++) begin
      if (!hold_o[1] && sent < 96) begin
        sym(1, 1'b1, 1'b0, 2'((sent / 16 + sent % 16) % 4));
        sent++;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    chk("t4_hold", hold_o, 4'b0010);
    chk("t4_sent", sent, 80);
    chk("t4_outv", out_valid_o, 1);
    out_ready_i = 1'b1;
    for (int t = 0; t < 100 && sent < 96; t++) begin
      if (!hold_o[1]) begin
        sym(1, 1'b1, 1'b0, 2'((sent / 16 + sent % 16) % 4));
        sent++;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    for (int w = 0; w < 6; w++) begin
      expect_word($sformatf("t4_w%0d", w), 1, 0, 16, bpw[w]);
    end
    expect_none("t4_noextra", 4);
    chk("t4_err", err_o, 0);
    chk("t4_hold_off", hold_o, 0);

    // overflow on ch3
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sym(3, 1'b1, 1'b1, 2'(i % 4));
      tick();
    end
    idle();
    chk("t5_hold", hold_o, 4'b1000);
    sym(3, 1'b1, 1'b0, SYM_DEL);
    tick();
    idle();
    chk("t5_err_set", err_o, 4'b1000);
    tick();
    tick();
    chk("t5_err_stays", err_o[3], 1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_word($sformatf("t5_w%0d", i), 3, 1, 1, 32'(i % 4));
    end
    sym(3, 1'b1, 1'b1, SYM_INS);
    tick();
    idle();
    expect_word("t5_after", 3, 1, 1, 32'h1);
    chk("t5_err_hold", err_o[3], 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("t5_err_clr", err_o, 0);

    // asynchronous reset mid-stream
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sym(1, 1'b1, 1'b1, 2'd0);
      tick();
    end
    idle();
    sym(1, 1'b1, 1'b0, 2'd0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      sym(0, 1'b1, 1'b0, SYM_MISMATCH);
      tick();
    end
    idle();
    chk("t6_pre_valid", out_valid_o, 1);
    chk("t6_pre_hold", hold_o[1], 1);
    chk("t6_pre_err", err_o[1], 1);
    #3;
    reset_i = 1'b0;
    #1;
    chk("t6_valid", out_valid_o, 0);
    chk("t6_hold", hold_o, 0);
    chk("t6_err", err_o, 0);
    q.delete();
    @(negedge clk);
    reset_i = 1'b1;
    tick();
    out_ready_i = 1'b1;
    sym(0, 1'b1, 1'b1, SYM_DEL);
    sym(1, 1'b1, 1'b1, SYM_INS);
    tick();
    idle();
    expect_word("t6_ch0", 0, 1, 1, 32'h2);
    expect_word("t6_ch1", 1, 1, 1, 32'h1);
    expect_none("t6_noextra", 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
